vector_player: RTL and testbench

Synthesizable stimulus/check engine sitting directly upstream of a combinational or single-cycle DUT in the MIPS processor bring-up flow. It holds a small vector memory, drives the DUT inputs from each stored vector, samples the DUT outputs one cycle later, compares them against the stored expected value and counts mismatches. It replaces the simulation-only vector loop so the same vector sets run on hardware, with completion and error count exposed as registers.

---
 rtl/vector_player.sv | 138 +++++++++++++
 tb/tb_vector_player.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/vector_player.sv
// vector_player: on-chip stimulus/check engine for a combinational or
// single-cycle DUT. Vectors are loaded into a small memory and then replayed.
// Each vector takes two cycles. The APPLY cycle drives the inputs. The CHECK
// cycle samples dut_out against the stored expected field. Mismatches and
// completed vectors are counted.
//
// Ports:
//   clock, reset            single clock, async active-high reset
//   load_en/addr/data       write one {inputs, expected} entry (ignored while busy)
//   start                   begin a run (honoured in IDLE or DONE only)
//   dut_in  -> DUT          registered stimulus
//   dut_out <- DUT          response, sampled in CHECK
//   busy, done, err_pulse   status (registered)
//   vectornum, errors       counters for the current/last run
module vector_player #(
  parameter int IN_W   = 3,
  parameter int OUT_W  = 1,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load_en,
  input  logic [ADDR_W-1:0]       load_addr,
  input  logic [IN_W+OUT_W-1:0]   load_data,
  input  logic                    start,
  output logic [IN_W-1:0]         dut_in,
  input  logic [OUT_W-1:0]        dut_out,
  output logic                    busy,
  output logic                    done,
  output logic                    err_pulse,
  output logic [CNT_W-1:0]        vectornum,
  output logic [CNT_W-1:0]        errors
);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_CHECK, S_DONE} state_t;

  state_t                  r_state;
  logic [IN_W+OUT_W-1:0]   r_mem [DEPTH];
  logic [DEPTH-1:0]        r_valid;
  logic [ADDR_W-1:0]       r_idx;
  logic [OUT_W-1:0]        r_exp;
  logic [IN_W-1:0]         r_dut_in;
  logic                    r_busy, r_done, r_err_pulse;
  logic [CNT_W-1:0]        r_vectornum, r_errors;

  logic                    w_we;
  logic [IN_W+OUT_W-1:0]   w_rd;
  logic [ADDR_W-1:0]       w_nidx;
  logic                    w_last;
  logic                    w_mis;

  // Writes are blocked for the whole run so the set under test cannot change
  // underneath the replay.
  assign w_we   = load_en && !r_busy;
  assign w_rd   = r_mem[r_idx];
  assign w_nidx = r_idx + 1'b1;
  // The explicit end-of-memory test keeps w_nidx from wrapping back to entry 0.
  assign w_last = (r_idx == ADDR_W'(DEPTH-1)) || !r_valid[w_nidx];
  assign w_mis  = (dut_out != r_exp);

  // Vector data has no reset; the valid bits alone define the set.
  always_ff @(posedge clock) begin
    if (w_we) r_mem[load_addr] <= load_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_idx       <= '0;
      r_exp       <= '0;
      r_dut_in    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_pulse <= 1'b0;
      r_vectornum <= '0;
      r_errors    <= '0;
    end else begin
      r_err_pulse <= 1'b0;
      if (w_we) r_valid[load_addr] <= 1'b1;
      case (r_state)
        S_IDLE, S_DONE: begin
          // r_valid[0] is the pre-write value, so a same-cycle load is not
          // visible to this start.
          if (start) begin
            r_vectornum <= '0;
            r_errors    <= '0;
            r_idx       <= '0;
            if (r_valid[0]) begin
              r_state <= S_APPLY;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end else begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        S_APPLY: begin
          r_dut_in <= w_rd[IN_W+OUT_W-1:OUT_W];
          r_exp    <= w_rd[OUT_W-1:0];
          r_state  <= S_CHECK;
        end
        S_CHECK: begin
          if (w_mis) begin
            r_err_pulse <= 1'b1;
            if (r_errors != {CNT_W{1'b1}}) r_errors <= r_errors + 1'b1;
          end
          r_vectornum <= r_vectornum + 1'b1;
          r_idx       <= w_nidx;
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_APPLY;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign dut_in    = r_dut_in;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err_pulse = r_err_pulse;
  assign vectornum = r_vectornum;
  assign errors    = r_errors;

endmodule

// File: tb/tb_vector_player.sv
module tb_vector_player;
  localparam int IN_W = 3, OUT_W = 1, DEPTH = 16, ADDR_W = 4, CNT_W = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              load_en = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [3:0]        load_data = '0;
  logic              start = 1'b0;
  logic [IN_W-1:0]   dut_in;
  logic [OUT_W-1:0]  dut_out;
  logic              busy, done, err_pulse;
  logic [CNT_W-1:0]  vectornum, errors;

  int n_assert = 0;
  int n_fail   = 0;

  // Shadow of what has been written and is valid.
  logic [3:0]        sh_mem [DEPTH];
  logic [DEPTH-1:0]  sh_valid = '0;

  // DUT under test: 3-input AND.
  assign dut_out = &dut_in;

  vector_player #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_dut (
    .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .err_pulse(err_pulse),
    .vectornum(vectornum), .errors(errors));

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Entry i of the AND table, optionally with its expected bit inverted.
  function automatic logic [3:0] vec(input int i, input bit inv);
    logic [2:0] a;
    a = i[2:0];
    return {a, (&a) ^ inv};
  endfunction

  task automatic load(input int addr, input logic [3:0] data);
    load_en = 1'b1; load_addr = addr[ADDR_W-1:0]; load_data = data;
    tick();
    load_en = 1'b0;
    sh_mem[addr] = data;
    sh_valid[addr] = 1'b1;
  endtask

  // Full run. At tick 'inj' a write to entry 1 and a start are driven while busy.
  task automatic run(input int inj);
    int k, j, exp_err;
    logic [3:0] e;
    logic mis;
    k = 0;
    while (k < DEPTH && sh_valid[k]) k++;
    exp_err = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (k == 0) begin
      chk("empty_done", done, 1);
      chk("empty_busy", busy, 0);
    end else begin
      chk("busy_after_start", busy, 1);
      for (int t = 1; t <= 2*k; t++) begin
        if (t == inj) begin
          load_en = 1'b1; load_addr = 1; load_data = 4'b0011; start = 1'b1;
        end
        tick();
        load_en = 1'b0; start = 1'b0;
        j = (t - 1) / 2;
        e = sh_mem[j];
        if (t % 2 == 1) begin
          chk("dut_in_apply", dut_in, e[3:1]);
          chk("err_pulse_low", err_pulse, 0);
        end else begin
          mis = ((&e[3:1]) != e[0]);
          if (mis) exp_err++;
          chk("err_pulse_check", err_pulse, mis);
        end
        chk("done_timing", done, t == 2*k);
        chk("busy_timing", busy, t != 2*k);
      end
    end
    chk("vectornum", vectornum, k);
    chk("errors", errors, exp_err);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_dut_in", dut_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_vectornum", vectornum, 0);
    chk("rst_errors", errors, 0);
    reset = 1'b0;
    tick();

    // Empty set: done one edge after start
    run(0);

    // 8 correct AND vectors
    for (int i = 0; i < 8; i++) load(i, vec(i, 1'b0));
    run(0);

    // Entries 2 and 5 with inverted expected bit
    load(2, vec(2, 1'b1));
    load(5, vec(5, 1'b1));
    run(0);
    chk("two_errors", errors, 2);

    // All 16 entries valid: stops after index 15, no wrap
    load(2, vec(2, 1'b0));
    load(5, vec(5, 1'b0));
    for (int i = 8; i < 16; i++) load(i, vec(i, 1'b0));
    run(0);
    tick(); tick(); tick();
    chk("full_done_hold", done, 1);
    chk("full_vnum_hold", vectornum, 16);
    chk("full_dut_in_hold", dut_in, 7);

    // Reset mid-run during CHECK of vector 3
    start = 1'b1; tick(); start = 1'b0;
    for (int t = 0; t < 7; t++) tick();
    chk("mid_busy", busy, 1);
    chk("mid_vnum", vectornum, 3);
    reset = 1'b1;
    #1;
    chk("async_dut_in", dut_in, 0);
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    chk("async_vnum", vectornum, 0);
    chk("async_errors", errors, 0);
    #2 reset = 1'b0;
    sh_valid = '0;
    tick();
    run(0);

    // Load entry 0 together with start: start sees the pre-write contents
    load_en = 1'b1; load_addr = 0; load_data = vec(0, 1'b0); start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    sh_mem[0] = vec(0, 1'b0); sh_valid[0] = 1'b1;
    chk("same_cycle_done", done, 1);
    chk("same_cycle_vnum", vectornum, 0);

    // Load and start while busy are ignored; rerun shows entry 1 unchanged
    for (int i = 1; i < 8; i++) load(i, vec(i, 1'b0));
    run(2);
    run(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end
endmodule
